chain_seq_ctrl: RTL
===================

// Module: chain_seq_ctrl
// PURPOSE
//   Sequencer for a registered shift/test chain of CHAIN_LEN flops (din -> dout, one stage per clk).
//   Shifts a PAT_W-bit pattern serially into the chain, captures the bits emerging at the chain
//   output, compares them with the pattern and reports pass/fail plus a mismatch count.
//   Sits between a host/config register block and the chain instance; owns the chain's din.
// PARAMETERS
//   CHAIN_LEN  2   number of flops in the controlled chain (>=1); fixed pattern-to-output latency
//   PAT_W      8   pattern width in bits (>=1); bit 0 is shifted first
//   CNT_W      8   width of the mismatch counter err_cnt (saturating)
// PORTS
//   clk        in   1          single clock for controller and chain
//   rst        in   1          synchronous reset, active-high
//   start      in   1          request a run; sampled only in IDLE
//   abort      in   1          terminate a run in progress; ignored in IDLE
//   pattern    in   PAT_W      pattern to shift; latched on accepted start
//   chain_din  out  1          serial data to chain input
//   chain_dout in   1          serial data from chain output
//   busy       out  1          high from the cycle after accepted start until the run ends
//   done       out  1          one-cycle pulse when a run completes (not on abort)
//   pass       out  1          last completed run matched on all PAT_W bits
//   capture    out  PAT_W      bits captured from chain_dout on the last run, bit 0 first received
//   err_cnt    out  CNT_W      mismatching bits of last run, saturates at 2**CNT_W-1
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge): state IDLE; busy=0, done=0, pass=0, capture=0, err_cnt=0,
//     chain_din=0, internal counter=0. Reset mid-run discards the run. Chain reset is driven by the
//     integrator from the same source (chain is async active-low: connect rst_n = ~rst).
//   - States: IDLE, RUN, DONE.
//     IDLE: start=1 -> latch pattern, clear capture/err_cnt/pass, k<=0, go RUN.
//     RUN: run index k = 0 .. PAT_W+CHAIN_LEN-1, one increment per clk.
//       chain_din (combinational from state/k/latched pattern) = pat[k] if k<PAT_W, else 0.
//       for k>=CHAIN_LEN: capture[k-CHAIN_LEN] <= chain_dout; if chain_dout != pat[k-CHAIN_LEN]
//       then err_cnt <= err_cnt+1 (saturating).
//       k = PAT_W+CHAIN_LEN-1 -> go DONE.
//       abort=1 -> go IDLE immediately; capture/err_cnt keep partial values, pass=0, no done.
//       abort has priority over the terminal transition in the same cycle.
//     DONE: one cycle; done=1, busy=0, pass = (err_cnt==0 including last-bit update); -> IDLE.
//   - chain_din=0 in IDLE and DONE.
//   - busy registered: 1 in RUN only. start while busy/DONE is ignored (not queued).
//   - Latency: start accepted at edge t0; done high during cycle t0+PAT_W+CHAIN_LEN+1.
//     Back-to-back: start held high restarts in the cycle after DONE.
//   - pass/capture/err_cnt hold until next accepted start or reset.
//   - Counter k sized ceil(log2(PAT_W+CHAIN_LEN+1)); no wrap within a run.
// TESTING
//   1. CHAIN_LEN=2, PAT_W=8, pattern=8'hA5, start 1 cycle -> chain_din=1,0,1,0,0,1,0,1 then 0,0;
//      capture=8'hA5, pass=1, err_cnt=0, done pulse 11 cycles after start edge.
//   2. Same, chain_dout forced 0 -> capture=8'h00, err_cnt=4, pass=0, done still pulses.
//   3. CNT_W=2, pattern=8'hFF, chain_dout forced 0 -> err_cnt saturates at 3, pass=0.
//   4. abort in RUN at k=5 -> busy=0 next cycle, no done, pass=0, chain_din=0; new start accepted.
//   5. rst=1 at k=3, start held high -> all outputs 0 after edge; run restarts after rst drops.
//   6. start pulsed during RUN and during DONE -> ignored; single done; start held -> back-to-back runs.

Source files
------------

// File: rtl/chain_seq_ctrl.sv
// -----------------------------------------------------------------------------
// chain_seq_ctrl
//   Sequencer for a registered shift/test chain of CHAIN_LEN flops. A run shifts
//   a PAT_W-bit pattern (bit 0 first) into the chain through chain_din, captures
//   the bits that emerge on chain_dout CHAIN_LEN cycles later, compares them to
//   the pattern, and reports pass/fail plus a saturating mismatch count.
//
// Ports
//   clk        in   1       clock shared with the chain
//   rst        in   1       synchronous reset, active-high
//   start      in   1       run request, sampled only in IDLE
//   abort      in   1       ends a run in progress (RUN only), no done pulse
//   pattern    in   PAT_W   pattern, latched when start is accepted
//   chain_din  out  1       serial data into the chain (0 outside the shift phase)
//   chain_dout in   1       serial data out of the chain
//   busy       out  1       1 while a run is in RUN
//   done       out  1       one-cycle pulse in DONE after a completed run
//   pass       out  1       last completed run matched on every bit
//   capture    out  PAT_W   bits received on the last run, bit 0 received first
//   err_cnt    out  CNT_W   mismatching bits of the last run, saturating
//   dbg_state  out  2       current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level request. It is taken on any rising clk edge where
// the FSM is in IDLE and start=1; busy rises in the following cycle. Requests
// that arrive while busy or in DONE are dropped, not queued, so a held start
// restarts one IDLE cycle after each DONE.
// -----------------------------------------------------------------------------
module chain_seq_ctrl #(
  parameter int CHAIN_LEN = 2,
  parameter int PAT_W     = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  output logic             chain_din,
  input  logic             chain_dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [PAT_W-1:0] capture,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  // Run index k walks 0 .. RUN_LEN-1; the width leaves room for RUN_LEN so
  // the increment on the terminal cycle never wraps.
  localparam int RUN_LEN = PAT_W + CHAIN_LEN;
  localparam int K_W     = $clog2(RUN_LEN + 1);

  localparam logic [K_W-1:0]   K_LAST  = K_W'(RUN_LEN - 1);
  localparam logic [K_W-1:0]   K_CL    = K_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [K_W-1:0]   k;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] capture_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic             pass_q;

  logic [K_W-1:0]   cap_idx;
  logic             cap_en;
  logic             din_bit;
  logic             exp_bit;

  assign capture   = capture_q;
  assign err_cnt   = err_cnt_q;
  assign pass      = pass_q;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Datapath decode
  //   din_bit : pat[k], naturally 0 once k >= PAT_W (no index matches)
  //   exp_bit : pat[k-CHAIN_LEN], the bit that should be on chain_dout now
  //   cap_en  : a chain output bit is due this cycle and the run continues;
  //             the cycle in which abort is seen stores nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    din_bit     = 1'b0;
    exp_bit     = 1'b0;
    cap_idx     = k - K_CL;
    cap_en      = (state == S_RUN) && !abort && (k >= K_CL);
    err_cnt_nxt = err_cnt_q;
    for (int i = 0; i < PAT_W; i++) begin
      if (k == K_W'(i))       din_bit = pat_q[i];
      if (cap_idx == K_W'(i)) exp_bit = pat_q[i];
    end
    if (cap_en && (chain_dout != exp_bit) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_nxt = err_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  //   abort is checked before the terminal-count exit so it wins on k=K_LAST.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    chain_din = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        chain_din = din_bit;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (k == K_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run registers: index, latched pattern, capture, mismatch count, pass flag.
  // pass is resolved on the edge into DONE using the count that already
  // includes the final bit, so it is valid during the done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      pat_q     <= '0;
      capture_q <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k         <= '0;
            pat_q     <= pattern;
            capture_q <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
          end
        end
        S_RUN: begin
          k         <= abort ? '0 : k + K_W'(1);
          err_cnt_q <= err_cnt_nxt;
          for (int i = 0; i < PAT_W; i++) begin
            if (cap_en && (cap_idx == K_W'(i))) capture_q[i] <= chain_dout;
          end
          if (!abort && (k == K_LAST)) begin
            pass_q <= (err_cnt_nxt == '0);
          end
        end
        default: begin
          k <= '0;
        end
      endcase
    end
  end

endmodule
